// File: rtl/vme_slave_responder.sv
// VMEbus A24/D16 slave: decodes a 64 KB window, turns each data strobe into one
// local register-bus access and answers with DTACK* (or BERR* on local timeout).
module vme_slave_responder #(
    parameter logic [7:0]  BASE_A24       = 8'h80,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        sys_rst_n,
    input  logic [23:1] vme_a,
    input  logic [5:0]  vme_am,
    input  logic        vme_as_n,
    input  logic        vme_ds0_n,
    input  logic        vme_ds1_n,
    input  logic        vme_write_n,
    input  logic        vme_lword_n,
    input  logic        vme_iack_n,
    input  logic [15:0] vme_db_in,
    output logic [15:0] vme_db_out,
    output logic        vme_db_oe,
    output logic        vme_dtack_n,
    output logic        vme_dtack_oe,
    output logic        vme_berr_n,
    output logic        vme_berr_oe,
    output logic [14:0] local_addr,
    output logic [1:0]  local_be,
    output logic [15:0] local_wdata,
    output logic        local_wr,
    output logic        local_rd,
    input  logic [15:0] local_rdata,
    input  logic        local_ack
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_IGNORE,
        S_WAIT_DS,
        S_ACCESS,
        S_RDATA,
        S_DTACK,
        S_BERR,
        S_RELEASE
    } state_t;

    localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    // Sync chains: [0] first stage, [1] synchronized level, [2] history.
    logic [2:0]  as_sync_q, ds0_sync_q, ds1_sync_q;
    logic [14:0] addr_q, addr_d;
    logic        write_n_q, write_n_d;
    logic [1:0]  be_q, be_d;
    logic [15:0] wdata_q, wdata_d;
    logic        wr_q, wr_d;
    logic        rd_q, rd_d;
    logic [15:0] timer_q, timer_d;
    logic        abort_q, abort_d;
    logic [15:0] db_out_q, db_out_d;
    logic        db_oe_q, db_oe_d;
    logic        dtack_n_q, dtack_n_d;
    logic        dtack_oe_q, dtack_oe_d;
    logic        berr_n_q, berr_n_d;
    logic        berr_oe_q, berr_oe_d;

    logic as_high, as_fall, ds_any_low, ds_both_high, ds_abort;
    logic am_ok, match, ack_ok, timed_out;

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            as_sync_q  <= '1;
            ds0_sync_q <= '1;
            ds1_sync_q <= '1;
        end else begin
            as_sync_q  <= {as_sync_q[1:0], vme_as_n};
            ds0_sync_q <= {ds0_sync_q[1:0], vme_ds0_n};
            ds1_sync_q <= {ds1_sync_q[1:0], vme_ds1_n};
        end
    end

    assign as_high      = as_sync_q[1];
    assign as_fall      = as_sync_q[2] & ~as_sync_q[1];
    assign ds_any_low   = ~ds0_sync_q[1] | ~ds1_sync_q[1];
    assign ds_both_high = ds0_sync_q[1] & ds1_sync_q[1];
    // A master abort is only believed after two consecutive idle samples.
    assign ds_abort     = ds_both_high & ds0_sync_q[2] & ds1_sync_q[2];

    always_comb begin
        unique case (vme_am)
            6'h39, 6'h3A, 6'h3D, 6'h3E: am_ok = 1'b1;
            default:                    am_ok = 1'b0;
        endcase
    end

    assign match     = am_ok && (vme_a[23:16] == BASE_A24) && vme_iack_n && vme_lword_n;
    assign ack_ok    = local_ack & ~(wr_q | rd_q);
    assign timed_out = (timer_q >= TMO);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        write_n_d = write_n_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        wr_d      = 1'b0;
        rd_d      = 1'b0;
        timer_d   = timer_q;
        abort_d   = abort_q;
        db_out_d  = db_out_q;
        db_oe_d   = db_oe_q;

        unique case (state_q)
            S_IDLE: begin
                if (as_fall) begin
                    if (match) begin
                        addr_d    = vme_a[15:1];
                        write_n_d = vme_write_n;
                        state_d   = S_WAIT_DS;
                    end else begin
                        state_d = S_IGNORE;
                    end
                end
            end
            S_IGNORE: begin
                if (as_high) state_d = S_IDLE;
            end
            S_WAIT_DS: begin
                if (as_high) begin
                    state_d = S_IDLE;
                end else if (ds_any_low) begin
                    // Direction is re-sampled per data strobe so the write half
                    // of a read-modify-write under one AS* is honoured.
                    write_n_d = vme_write_n;
                    be_d      = {~ds1_sync_q[1], ~ds0_sync_q[1]};
                    wdata_d   = vme_db_in;
                    wr_d      = ~vme_write_n;
                    rd_d      = vme_write_n;
                    timer_d   = '0;
                    abort_d   = 1'b0;
                    state_d   = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (timer_q != 16'hFFFF) timer_d = timer_q + 16'd1;
                if (ds_abort) abort_d = 1'b1;
                if (ack_ok) begin
                    if (abort_q || ds_abort) begin
                        state_d = S_RELEASE;
                    end else if (write_n_q) begin
                        db_out_d = local_rdata;
                        db_oe_d  = 1'b1;
                        state_d  = S_RDATA;
                    end else begin
                        state_d = S_DTACK;
                    end
                end else if (timed_out) begin
                    state_d = (abort_q || ds_abort) ? S_RELEASE : S_BERR;
                end
            end
            S_RDATA: begin
                state_d = S_DTACK;
            end
            S_DTACK, S_BERR: begin
                if (ds_both_high) state_d = S_RELEASE;
            end
            S_RELEASE: begin
                state_d = as_high ? S_IDLE : S_WAIT_DS;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d == S_RELEASE || state_d == S_IDLE) db_oe_d = 1'b0;

        dtack_oe_d = (state_d == S_DTACK) || (state_d == S_RELEASE);
        dtack_n_d  = (state_d != S_DTACK);
        berr_oe_d  = (state_d == S_BERR);
        berr_n_d   = (state_d != S_BERR);
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            write_n_q  <= 1'b1;
            be_q       <= '0;
            wdata_q    <= '0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            timer_q    <= '0;
            abort_q    <= 1'b0;
            db_out_q   <= '0;
            db_oe_q    <= 1'b0;
            dtack_n_q  <= 1'b1;
            dtack_oe_q <= 1'b0;
            berr_n_q   <= 1'b1;
            berr_oe_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            write_n_q  <= write_n_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            timer_q    <= timer_d;
            abort_q    <= abort_d;
            db_out_q   <= db_out_d;
            db_oe_q    <= db_oe_d;
            dtack_n_q  <= dtack_n_d;
            dtack_oe_q <= dtack_oe_d;
            berr_n_q   <= berr_n_d;
            berr_oe_q  <= berr_oe_d;
        end
    end

    assign vme_db_out   = db_out_q;
    assign vme_db_oe    = db_oe_q;
    assign vme_dtack_n  = dtack_n_q;
    assign vme_dtack_oe = dtack_oe_q;
    assign vme_berr_n   = berr_n_q;
    assign vme_berr_oe  = berr_oe_q;
    assign local_addr   = addr_q;
    assign local_be     = be_q;
    assign local_wdata  = wdata_q;
    assign local_wr     = wr_q;
    assign local_rd     = rd_q;

endmodule

// File: tb/tb_vme_slave_responder.sv
// Bench for vme_slave_responder: vector table of VME cycles, a strobe scoreboard,
// plus read-modify-write and mid-cycle reset sequences.
module tb_vme_slave_responder;

    localparam int TMO   = 8;
    localparam int NOACK = -1;

    logic        clk = 1'b0;
    logic        sys_rst_n;
    logic [23:1] vme_a;
    logic [5:0]  vme_am;
    logic        vme_as_n, vme_ds0_n, vme_ds1_n, vme_write_n, vme_lword_n, vme_iack_n;
    logic [15:0] vme_db_in;
    logic [15:0] vme_db_out;
    logic        vme_db_oe, vme_dtack_n, vme_dtack_oe, vme_berr_n, vme_berr_oe;
    logic [14:0] local_addr;
    logic [1:0]  local_be;
    logic [15:0] local_wdata;
    logic        local_wr, local_rd;
    logic [15:0] local_rdata;
    logic        local_ack;

    vme_slave_responder #(
        .BASE_A24       (8'h80),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .sys_rst_n    (sys_rst_n),
        .vme_a        (vme_a),
        .vme_am       (vme_am),
        .vme_as_n     (vme_as_n),
        .vme_ds0_n    (vme_ds0_n),
        .vme_ds1_n    (vme_ds1_n),
        .vme_write_n  (vme_write_n),
        .vme_lword_n  (vme_lword_n),
        .vme_iack_n   (vme_iack_n),
        .vme_db_in    (vme_db_in),
        .vme_db_out   (vme_db_out),
        .vme_db_oe    (vme_db_oe),
        .vme_dtack_n  (vme_dtack_n),
        .vme_dtack_oe (vme_dtack_oe),
        .vme_berr_n   (vme_berr_n),
        .vme_berr_oe  (vme_berr_oe),
        .local_addr   (local_addr),
        .local_be     (local_be),
        .local_wdata  (local_wdata),
        .local_wr     (local_wr),
        .local_rd     (local_rd),
        .local_rdata  (local_rdata),
        .local_ack    (local_ack)
    );

    always #4 clk = ~clk;

    typedef struct {
        logic [5:0]  am;
        logic [23:0] a;
        logic        wr;
        logic [1:0]  ds;
        logic        lword_n;
        logic        iack_n;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          ack_dly;
        logic        match;
    } vec_t;

    typedef struct {
        logic        wr;
        logic [14:0] addr;
        logic [1:0]  be;
        logic [15:0] wdata;
    } exp_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_strobe = 0;
    int   n_expect = 0;
    exp_t sb[$];
    exp_t mon_e;
    vec_t vt[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic wr, input logic [14:0] addr, input logic [1:0] be,
                            input logic [15:0] wdata);
        exp_t e;
        e.wr = wr; e.addr = addr; e.be = be; e.wdata = wdata;
        sb.push_back(e);
        n_expect++;
    endtask

    always @(negedge clk) begin
        if (local_wr || local_rd) begin
            n_strobe++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_strobe: actual wr=%0b rd=%0b addr=%h, required no strobe",
                         local_wr, local_rd, local_addr);
            end else begin
                mon_e = sb.pop_front();
                chk("strobe_fields",
                    64'({local_wr, local_rd, local_addr, local_be, local_wdata}),
                    64'({mon_e.wr, ~mon_e.wr, mon_e.addr, mon_e.be, mon_e.wdata}));
            end
        end
    end

    task automatic wait_strobe(output int k);
        k = 0;
        do begin
            @(posedge clk); #1; k++;
        end while (!(local_wr || local_rd) && k < 12);
    endtask

    task automatic wait_berr(output int k);
        k = 0;
        do begin
            @(posedge clk); #1; k++;
        end while (!(vme_berr_oe && !vme_berr_n) && k < 30);
    endtask

    task automatic wait_release(output int k);
        k = 0;
        do begin
            @(posedge clk); #1; k++;
        end while (!(vme_dtack_n && !vme_berr_oe) && k < 10);
    endtask

    task automatic check_release(input string tag);
        int k;
        vme_ds0_n = 1'b1; vme_ds1_n = 1'b1;
        wait_release(k);
        chk({tag, "_release_lat"}, 64'(k <= 3), 64'(1));
        chk({tag, "_release_cycle"},
            64'({vme_dtack_oe, vme_dtack_n, vme_db_oe, vme_berr_oe, vme_berr_n}), 64'(5'b11001));
        @(posedge clk); #1;
        chk({tag, "_release_end"},
            64'({vme_dtack_oe, vme_db_oe, vme_berr_oe, vme_dtack_n, vme_berr_n}), 64'(5'b00011));
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   k;
        logic drv;
        string tag;
        tag = $sformatf("v%0d", idx);
        vme_a = v.a[23:1]; vme_am = v.am; vme_write_n = ~v.wr;
        vme_lword_n = v.lword_n; vme_iack_n = v.iack_n; vme_db_in = v.wdata;
        @(posedge clk); #1;
        vme_as_n = 1'b0;
        if (v.match) push_exp(v.wr, v.a[15:1], v.ds, v.wdata);
        repeat (2) @(posedge clk); #1;
        vme_ds0_n = ~v.ds[0]; vme_ds1_n = ~v.ds[1];
        if (v.match) begin
            wait_strobe(k);
            chk({tag, "_strobe_lat"}, 64'(k), 64'(3));
            chk({tag, "_no_early_drive"}, 64'({vme_dtack_oe, vme_berr_oe, vme_db_oe}), 64'(0));
            if (v.ack_dly == NOACK) begin
                wait_berr(k);
                chk({tag, "_berr_lat"}, 64'(k), 64'(TMO + 1));
                local_ack = 1'b1; local_rdata = 16'hDEAD;
                @(posedge clk); #1;
                local_ack = 1'b0;
                chk({tag, "_late_ack_ignored"},
                    64'({vme_berr_n, vme_berr_oe, vme_dtack_oe, vme_db_oe}), 64'(4'b0100));
            end else begin
                repeat (v.ack_dly) @(posedge clk);
                #1;
                local_ack = 1'b1; local_rdata = v.rdata;
                @(posedge clk); #1;
                local_ack = 1'b0;
                if (v.wr) begin
                    chk({tag, "_dtack"}, 64'({vme_dtack_n, vme_dtack_oe}), 64'(2'b01));
                end else begin
                    chk({tag, "_rdata_lead"}, 64'({vme_db_oe, vme_db_out, vme_dtack_n}),
                        64'({1'b1, v.rdata, 1'b1}));
                    @(posedge clk); #1;
                    chk({tag, "_dtack"}, 64'({vme_dtack_n, vme_dtack_oe, vme_db_oe}), 64'(3'b011));
                end
            end
            check_release(tag);
        end else begin
            drv = 1'b0;
            repeat (12) begin
                @(posedge clk); #1;
                drv = drv | vme_dtack_oe | vme_berr_oe | vme_db_oe;
            end
            chk({tag, "_nomatch_no_drive"}, 64'(drv), 64'(0));
            vme_ds0_n = 1'b1; vme_ds1_n = 1'b1;
        end
        @(posedge clk); #1;
        vme_as_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_sb_drained"}, 64'(sb.size()), 64'(0));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: actual timeout, required test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k;
        logic [23:0] a24;
        sys_rst_n = 1'b0;
        vme_a = '0; vme_am = '0; vme_as_n = 1'b1; vme_ds0_n = 1'b1; vme_ds1_n = 1'b1;
        vme_write_n = 1'b1; vme_lword_n = 1'b1; vme_iack_n = 1'b1; vme_db_in = '0;
        local_rdata = '0; local_ack = 1'b0;

        //         am     address       wr    ds     lw    iack  wdata     rdata    ack    match
        vt[0] = '{6'h39, 24'h800124, 1'b1, 2'b11, 1'b1, 1'b1, 16'hBEEF, 16'h0000, 4,     1'b1};
        vt[1] = '{6'h3A, 24'h80ABCE, 1'b0, 2'b10, 1'b1, 1'b1, 16'h1111, 16'h5A00, 2,     1'b1};
        vt[2] = '{6'h09, 24'h800124, 1'b1, 2'b11, 1'b1, 1'b1, 16'h2222, 16'h0000, 3,     1'b0};
        vt[3] = '{6'h39, 24'h810124, 1'b1, 2'b11, 1'b1, 1'b1, 16'h3333, 16'h0000, 3,     1'b0};
        vt[4] = '{6'h39, 24'h800124, 1'b1, 2'b11, 1'b0, 1'b1, 16'h4444, 16'h0000, 3,     1'b0};
        vt[5] = '{6'h3D, 24'h800124, 1'b0, 2'b11, 1'b1, 1'b0, 16'h5555, 16'h0000, 3,     1'b0};
        vt[6] = '{6'h3D, 24'h80FFFE, 1'b1, 2'b01, 1'b1, 1'b1, 16'h1234, 16'h0000, 1,     1'b1};
        vt[7] = '{6'h3E, 24'h800000, 1'b0, 2'b11, 1'b1, 1'b1, 16'h6666, 16'hA5C3, TMO,   1'b1};
        vt[8] = '{6'h39, 24'h800010, 1'b1, 2'b11, 1'b1, 1'b1, 16'h7777, 16'h0000, NOACK, 1'b1};
        vt[9] = '{6'h3A, 24'h800A02, 1'b0, 2'b01, 1'b1, 1'b1, 16'h8888, 16'h0000, NOACK, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_bus", 64'({vme_dtack_n, vme_dtack_oe, vme_berr_n, vme_berr_oe, vme_db_oe}),
            64'(5'b10100));
        chk("reset_local", 64'({vme_db_out, local_wr, local_rd, local_addr, local_be}), 64'(0));
        chk("reset_wdata", 64'(local_wdata), 64'(0));
        sys_rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) run_vec(vt[i], i);

        // Read-modify-write: one AS*, read then write; second address must not be decoded.
        a24 = 24'h800246;
        vme_a = a24[23:1]; vme_am = 6'h39; vme_write_n = 1'b1; vme_db_in = 16'h0F0F;
        @(posedge clk); #1;
        vme_as_n = 1'b0;
        push_exp(1'b0, 15'h0123, 2'b11, 16'h0F0F);
        repeat (2) @(posedge clk);
        #1;
        vme_ds0_n = 1'b0; vme_ds1_n = 1'b0;
        wait_strobe(k);
        chk("rmw_rd_lat", 64'(k), 64'(3));
        @(posedge clk); #1;
        local_ack = 1'b1; local_rdata = 16'h7E57;
        @(posedge clk); #1;
        local_ack = 1'b0;
        chk("rmw_rd_data", 64'({vme_db_oe, vme_db_out}), 64'({1'b1, 16'h7E57}));
        @(posedge clk); #1;
        chk("rmw_rd_dtack", 64'({vme_dtack_n, vme_dtack_oe}), 64'(2'b01));
        check_release("rmw_rd");
        a24 = 24'h810000;
        vme_a = a24[23:1]; vme_am = 6'h09; vme_write_n = 1'b0; vme_db_in = 16'hC0DE;
        push_exp(1'b1, 15'h0123, 2'b11, 16'hC0DE);
        repeat (2) @(posedge clk);
        #1;
        vme_ds0_n = 1'b0; vme_ds1_n = 1'b0;
        wait_strobe(k);
        chk("rmw_wr_lat", 64'(k), 64'(3));
        @(posedge clk); #1;
        local_ack = 1'b1;
        @(posedge clk); #1;
        local_ack = 1'b0;
        chk("rmw_wr_dtack", 64'({vme_dtack_n, vme_dtack_oe}), 64'(2'b01));
        check_release("rmw_wr");
        vme_as_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("rmw_sb_drained", 64'(sb.size()), 64'(0));

        // Reset while DTACK* is driven: enables drop at once, then a normal write works.
        vme_a = vt[0].a[23:1]; vme_am = vt[0].am; vme_write_n = 1'b0; vme_db_in = 16'h9999;
        @(posedge clk); #1;
        vme_as_n = 1'b0;
        push_exp(1'b1, vt[0].a[15:1], 2'b11, 16'h9999);
        repeat (2) @(posedge clk);
        #1;
        vme_ds0_n = 1'b0; vme_ds1_n = 1'b0;
        wait_strobe(k);
        @(posedge clk); #1;
        local_ack = 1'b1;
        @(posedge clk); #1;
        local_ack = 1'b0;
        chk("rst_pre_dtack", 64'({vme_dtack_n, vme_dtack_oe}), 64'(2'b01));
        #1 sys_rst_n = 1'b0;
        #1;
        chk("rst_mid_release",
            64'({vme_dtack_oe, vme_berr_oe, vme_db_oe, vme_dtack_n, vme_berr_n}), 64'(5'b00011));
        chk("rst_mid_local", 64'({local_wr, local_rd, local_addr}), 64'(0));
        vme_ds0_n = 1'b1; vme_ds1_n = 1'b1; vme_as_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 sys_rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_post_idle", 64'({vme_dtack_oe, vme_berr_oe, vme_db_oe}), 64'(0));
        run_vec(vt[0], 10);

        chk("strobe_count", 64'(n_strobe), 64'(n_expect));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
